// File: rtl/au_ptr_pkg.sv
// au_ptr_pkg
//  Shared constants and types for the AU-4 pointer generator.
//  Holds the H1/H2 flag nibbles, SS bits, fixed fill bytes, pointer range,
//  the row-4 slot classification enum and the per-channel pointer FSM enum.
//  Optional AIS support in the users of this package is enabled by the
//  macro AU_PTRGEN_AIS_EN; nothing in the package depends on it.
package au_ptr_pkg;

   localparam logic [3:0] H1_NORM = 4'b0110;
   localparam logic [3:0] H1_NDF  = 4'b1001;
   localparam logic [1:0] SS_AU4  = 2'b10;
   localparam logic [7:0] Y_BYTE  = 8'h9B;
   localparam logic [7:0] FF_BYTE = 8'hFF;
   localparam logic [7:0] H3_BYTE = 8'h00;
   localparam logic [9:0] PTR_MAX = 10'd782;
   localparam logic [9:0] PTR_RST = 10'd522;

   // I bits are D9,D7,D5,D3,D1 and D bits are D8,D6,D4,D2,D0 of the pointer
   localparam logic [9:0] I_MASK  = 10'h2AA;
   localparam logic [9:0] D_MASK  = 10'h155;

   typedef enum logic [2:0] {
      SL_H1,
      SL_Y,
      SL_H2,
      SL_FF,
      SL_H3
   } slot_t;

   typedef enum logic [1:0] {
      ST_NORM,
      ST_INC,
      ST_DEC,
      ST_NDF
   } chst_t;

   // Map a row-4 slot number 0..8 onto the kind of byte it carries
   function automatic slot_t slot_kind(input logic [3:0] slot);
      slot_t k;
      case (slot)
         4'd0:       k = SL_H1;
         4'd1, 4'd2: k = SL_Y;
         4'd3:       k = SL_H2;
         4'd4, 4'd5: k = SL_FF;
         default:    k = SL_H3;
      endcase
      return k;
   endfunction

endpackage

// File: rtl/au_ptr_ch.sv
// au_ptr_ch
//  One AU-4 pointer channel: sticky justification/NDF requests, the
//  event-spacing counter, the NORM/INC/DEC/NDF state machine and the
//  current pointer. Produces this channel's H1/H2 bytes and its flags.
//  Optional: AU_PTRGEN_AIS_EN adds the ais input.
// Ports
//  clk19, rst_n        clock, asynchronous active-low reset
//  txsof               frame start: pending requests evaluated here
//  ptr_new             NDF pointer, captured whenever ld_req is high
//  ld_req/inc_req/dec_req  request strobes, held sticky until txsof
//  ais                 (AU_PTRGEN_AIS_EN only) channel in AIS
//  req_ack/req_rej     one-cycle result pulses after an evaluating txsof
//  ptr_cur             current active pointer
//  h1_byte/h2_byte     pointer word bytes for the current frame
//  pstuff              positive stuff frame
//  dec_on              negative stuff frame (H3 carries payload)
module au_ptr_ch
   import au_ptr_pkg::*;
#(
   parameter int SPACING = 3
) (
   input  logic       clk19,
   input  logic       rst_n,
   input  logic       txsof,
   input  logic [9:0] ptr_new,
   input  logic       ld_req,
   input  logic       inc_req,
   input  logic       dec_req,
`ifdef AU_PTRGEN_AIS_EN
   input  logic       ais,
`endif
   output logic       req_ack,
   output logic       req_rej,
   output logic [9:0] ptr_cur,
   output logic [7:0] h1_byte,
   output logic [7:0] h2_byte,
   output logic       pstuff,
   output logic       dec_on
);

   localparam int CW = (SPACING > 0) ? $clog2(SPACING + 1) : 1;
   localparam logic [CW-1:0] CNT_SAT = CW'(SPACING);

   chst_t         st, st_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [9:0]    ptr_nxt, ptr_lat, dword;
   logic [3:0]    nnnn;
   logic          ld_st, inc_st, dec_st;
   logic          ack_nxt, rej_nxt, ev;
   logic          ais_hold, ais_ndf;

`ifdef AU_PTRGEN_AIS_EN
   logic ais_prev, ais_ndf_q;

   // Remember a falling edge of ais so the next frame start forces an NDF
   // that re-announces the unchanged pointer to the far end.
   always_ff @(posedge clk19 or negedge rst_n) begin
      if (!rst_n) begin
         ais_prev  <= 1'b0;
         ais_ndf_q <= 1'b0;
      end else begin
         ais_prev  <= ais;
         ais_ndf_q <= (ais_ndf_q & ~txsof) | (ais_prev & ~ais);
      end
   end

   assign ais_hold = ais;
   assign ais_ndf  = ais_ndf_q;
`else
   assign ais_hold = 1'b0;
   assign ais_ndf  = 1'b0;
`endif

   // Requests stay pending until the next frame start. A request arriving on
   // the txsof cycle itself survives the clear and waits for the next frame.
   always_ff @(posedge clk19 or negedge rst_n) begin
      if (!rst_n) begin
         ld_st   <= 1'b0;
         inc_st  <= 1'b0;
         dec_st  <= 1'b0;
         ptr_lat <= PTR_RST;
      end else begin
         ld_st  <= ld_req  | (ld_st  & ~txsof);
         inc_st <= inc_req | (inc_st & ~txsof);
         dec_st <= dec_req | (dec_st & ~txsof);
         if (ld_req)
            ptr_lat <= ptr_new;
      end
   end

   // State, pointer, spacing counter and result pulses.
   always_ff @(posedge clk19 or negedge rst_n) begin
      if (!rst_n) begin
         st      <= ST_NORM;
         ptr_cur <= PTR_RST;
         cnt     <= CNT_SAT;
         req_ack <= 1'b0;
         req_rej <= 1'b0;
      end else begin
         st      <= st_nxt;
         ptr_cur <= ptr_nxt;
         cnt     <= cnt_nxt;
         req_ack <= ack_nxt;
         req_rej <= rej_nxt;
      end
   end

   // Frame-start evaluation. A finishing INC/DEC frame applies its pointer
   // step first; an NDF accepted on the same txsof overrides that step.
   // Only an accepted event (or AIS release NDF) restarts the spacing count.
   always_comb begin
      st_nxt  = st;
      ptr_nxt = ptr_cur;
      cnt_nxt = cnt;
      ack_nxt = 1'b0;
      rej_nxt = 1'b0;
      ev      = 1'b0;
      if (txsof) begin
         st_nxt = ST_NORM;
         if (st == ST_INC)
            ptr_nxt = (ptr_cur == PTR_MAX) ? 10'd0 : ptr_cur + 10'd1;
         else if (st == ST_DEC)
            ptr_nxt = (ptr_cur == 10'd0) ? PTR_MAX : ptr_cur - 10'd1;

         if (ais_hold) begin
            rej_nxt = ld_st | inc_st | dec_st;
         end else if (ais_ndf) begin
            st_nxt  = ST_NDF;
            ev      = 1'b1;
            rej_nxt = ld_st | inc_st | dec_st;
         end else if (ld_st) begin
            if (ptr_lat <= PTR_MAX) begin
               st_nxt  = ST_NDF;
               ptr_nxt = ptr_lat;
               ev      = 1'b1;
               ack_nxt = 1'b1;
            end else begin
               rej_nxt = 1'b1;
            end
         end else if (inc_st && dec_st) begin
            rej_nxt = 1'b1;
         end else if (inc_st || dec_st) begin
            if (cnt == CNT_SAT) begin
               st_nxt  = inc_st ? ST_INC : ST_DEC;
               ev      = 1'b1;
               ack_nxt = 1'b1;
            end else begin
               rej_nxt = 1'b1;
            end
         end

         if (ev)
            cnt_nxt = '0;
         else if (cnt != CNT_SAT)
            cnt_nxt = cnt + CW'(1);
      end
   end

   // H1/H2 word NNNN SS D9..D0 with the I or D bits inverted during a
   // justification frame.
   always_comb begin
      nnnn  = H1_NORM;
      dword = ptr_cur;
      case (st)
         ST_INC:  dword = ptr_cur ^ I_MASK;
         ST_DEC:  dword = ptr_cur ^ D_MASK;
         ST_NDF:  nnnn  = H1_NDF;
         default: dword = ptr_cur;
      endcase
      h1_byte = {nnnn, SS_AU4, dword[9:8]};
      h2_byte = dword[7:0];
   end

   assign pstuff = (st == ST_INC);
   assign dec_on = (st == ST_DEC);

endmodule

// File: rtl/au_ptrgen_nch.sv
// au_ptrgen_nch
//  AU-4 pointer generator for the STM-N row-4 H1..H3 field with NCH
//  byte-interleaved AU-4s. Walks the 9*NCH pointer bytes in STM-N order and
//  muxes each channel's H1/H2, the Y and FF fill and H3 into a registered byte.
//  Optional: AU_PTRGEN_AIS_EN adds input ais[NCH].
// Ports
//  clk19, rst_n    clock, asynchronous active-low reset
//  txsof           frame start; clears position, evaluates requests
//  en              emit the byte at the current position and advance
//  ptr_new         10 bits per channel, NDF pointer
//  ld_req/inc_req/dec_req  per-channel request strobes
//  req_ack/req_rej per-channel result pulses
//  ptr_cur         10 bits per channel, active pointer
//  wdat/wvalid     registered pointer byte and its valid
//  h3_data         with wvalid: this H3 byte carries payload
//  pstuff          per-channel positive stuff frame
module au_ptrgen_nch
   import au_ptr_pkg::*;
#(
   parameter int NCH     = 1,
   parameter int SPACING = 3
) (
   input  logic              clk19,
   input  logic              rst_n,
   input  logic              txsof,
   input  logic              en,
   input  logic [10*NCH-1:0] ptr_new,
   input  logic [NCH-1:0]    ld_req,
   input  logic [NCH-1:0]    inc_req,
   input  logic [NCH-1:0]    dec_req,
`ifdef AU_PTRGEN_AIS_EN
   input  logic [NCH-1:0]    ais,
`endif
   output logic [NCH-1:0]    req_ack,
   output logic [NCH-1:0]    req_rej,
   output logic [10*NCH-1:0] ptr_cur,
   output logic [7:0]        wdat,
   output logic              wvalid,
   output logic              h3_data,
   output logic [NCH-1:0]    pstuff
);

   localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam logic [CHW-1:0] CH_LAST = CHW'(NCH - 1);

   logic [CHW-1:0]   ch;
   logic [3:0]       slot;
   logic             framed, emit;
   logic [8*NCH-1:0] h1_all, h2_all;
   logic [NCH-1:0]   dec_all, ais_all;
   logic [7:0]       byte_nxt;
   logic             h3_nxt;
   int               sel;

`ifdef AU_PTRGEN_AIS_EN
   assign ais_all = ais;
`else
   assign ais_all = '0;
`endif

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      au_ptr_ch #(
         .SPACING (SPACING)
      ) u_ch (
         .clk19   (clk19),
         .rst_n   (rst_n),
         .txsof   (txsof),
         .ptr_new (ptr_new[g*10 +: 10]),
         .ld_req  (ld_req[g]),
         .inc_req (inc_req[g]),
         .dec_req (dec_req[g]),
`ifdef AU_PTRGEN_AIS_EN
         .ais     (ais[g]),
`endif
         .req_ack (req_ack[g]),
         .req_rej (req_rej[g]),
         .ptr_cur (ptr_cur[g*10 +: 10]),
         .h1_byte (h1_all[g*8 +: 8]),
         .h2_byte (h2_all[g*8 +: 8]),
         .pstuff  (pstuff[g]),
         .dec_on  (dec_all[g])
      );
   end

   // Bytes are only emitted once a frame start has been seen since reset,
   // and never on the txsof cycle itself, which only rewinds the position.
   assign emit = en & framed & ~txsof;

   // Position walks channel-fastest; the last position of the field is
   // sticky so surplus enables repeat the final H3 byte.
   always_ff @(posedge clk19 or negedge rst_n) begin
      if (!rst_n) begin
         ch     <= '0;
         slot   <= 4'd0;
         framed <= 1'b0;
      end else begin
         framed <= framed | txsof;
         if (txsof) begin
            ch   <= '0;
            slot <= 4'd0;
         end else if (en) begin
            if (ch == CH_LAST) begin
               if (slot != 4'd8) begin
                  ch   <= '0;
                  slot <= slot + 4'd1;
               end
            end else begin
               ch <= ch + CHW'(1);
            end
         end
      end
   end

   // Select the byte for the current position; AIS overwrites the H1, H2
   // and H3 bytes of its channel with all-ones but leaves the Y bytes alone.
   always_comb begin
      sel      = int'(ch);
      byte_nxt = H3_BYTE;
      h3_nxt   = 1'b0;
      case (slot_kind(slot))
         SL_H1: byte_nxt = ais_all[sel] ? FF_BYTE : h1_all[sel*8 +: 8];
         SL_Y:  byte_nxt = Y_BYTE;
         SL_H2: byte_nxt = ais_all[sel] ? FF_BYTE : h2_all[sel*8 +: 8];
         SL_FF: byte_nxt = FF_BYTE;
         SL_H3: begin
            byte_nxt = ais_all[sel] ? FF_BYTE : H3_BYTE;
            h3_nxt   = dec_all[sel] & ~ais_all[sel];
         end
         default: byte_nxt = H3_BYTE;
      endcase
   end

   // Output register: one cycle of latency from en to wdat/wvalid.
   always_ff @(posedge clk19 or negedge rst_n) begin
      if (!rst_n) begin
         wdat    <= 8'h00;
         wvalid  <= 1'b0;
         h3_data <= 1'b0;
      end else begin
         wvalid  <= emit;
         h3_data <= emit & h3_nxt;
         if (emit)
            wdat <= byte_nxt;
      end
   end

endmodule

// File: tb/tb_au_ptrgen_nch.sv
// tb_au_ptrgen_nch
//  Directed bench for au_ptrgen_nch: one NCH=1 instance for the pointer
//  events and one NCH=4 instance for interleaving. Expected bytes are
//  hand-computed constants. AIS steps only exist with AU_PTRGEN_AIS_EN.
module tb_au_ptrgen_nch;

   logic        clk19 = 1'b0;
   logic        rst_n = 1'b0;

   logic        txsof1 = 1'b0, en1 = 1'b0;
   logic [9:0]  ptr_new1 = 10'd0;
   logic        ld_req1 = 1'b0, inc_req1 = 1'b0, dec_req1 = 1'b0;
   logic        req_ack1, req_rej1, wvalid1, h3_data1, pstuff1;
   logic [9:0]  ptr_cur1;
   logic [7:0]  wdat1;
`ifdef AU_PTRGEN_AIS_EN
   logic        ais1 = 1'b0;
   logic [3:0]  ais4 = 4'b0000;
`endif

   logic        txsof4 = 1'b0, en4 = 1'b0;
   logic [39:0] ptr_new4 = 40'd0;
   logic [3:0]  ld_req4 = 4'b0, inc_req4 = 4'b0, dec_req4 = 4'b0;
   logic [3:0]  req_ack4, req_rej4, pstuff4;
   logic [39:0] ptr_cur4;
   logic [7:0]  wdat4;
   logic        wvalid4, h3_data4;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  b1 [9];
   logic        h3q [9];
   logic        v1 [9];
   logic [7:0]  b4 [36];

   always #5 clk19 = ~clk19;

   au_ptrgen_nch #(.NCH(1), .SPACING(3)) dut1 (
      .clk19   (clk19),
      .rst_n   (rst_n),
      .txsof   (txsof1),
      .en      (en1),
      .ptr_new (ptr_new1),
      .ld_req  (ld_req1),
      .inc_req (inc_req1),
      .dec_req (dec_req1),
`ifdef AU_PTRGEN_AIS_EN
      .ais     (ais1),
`endif
      .req_ack (req_ack1),
      .req_rej (req_rej1),
      .ptr_cur (ptr_cur1),
      .wdat    (wdat1),
      .wvalid  (wvalid1),
      .h3_data (h3_data1),
      .pstuff  (pstuff1)
   );

   au_ptrgen_nch #(.NCH(4), .SPACING(3)) dut4 (
      .clk19   (clk19),
      .rst_n   (rst_n),
      .txsof   (txsof4),
      .en      (en4),
      .ptr_new (ptr_new4),
      .ld_req  (ld_req4),
      .inc_req (inc_req4),
      .dec_req (dec_req4),
`ifdef AU_PTRGEN_AIS_EN
      .ais     (ais4),
`endif
      .req_ack (req_ack4),
      .req_rej (req_rej4),
      .ptr_cur (ptr_cur4),
      .wdat    (wdat4),
      .wvalid  (wvalid4),
      .h3_data (h3_data4),
      .pstuff  (pstuff4)
   );

   task automatic tick();
      @(posedge clk19);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One cycle of stimulus on the NCH=1 instance
   task automatic applyStimulus(input logic sof, input logic ld, input logic inc,
                                input logic dec, input logic [9:0] pn);
      txsof1   = sof;
      ld_req1  = ld;
      inc_req1 = inc;
      dec_req1 = dec;
      ptr_new1 = pn;
      tick();
      txsof1   = 1'b0;
      ld_req1  = 1'b0;
      inc_req1 = 1'b0;
      dec_req1 = 1'b0;
   endtask

   task automatic frameStart1();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, ptr_new1);
   endtask

   task automatic readFrame1();
      for (int i = 0; i < 9; i++) begin
         en1 = 1'b1;
         tick();
         b1[i]  = wdat1;
         h3q[i] = h3_data1;
         v1[i]  = wvalid1;
      end
      en1 = 1'b0;
   endtask

   task automatic readFrame4();
      for (int i = 0; i < 36; i++) begin
         en4 = 1'b1;
         tick();
         b4[i] = wdat4;
      end
      en4 = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [7:0] expn [9];
      expn = '{8'h6A, 8'h9B, 8'h9B, 8'h0A, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00};

      #23;
      checkOutput("rst_wdat",   16'(wdat1),    16'h00);
      checkOutput("rst_wvalid", 16'(wvalid1),  16'h0);
      checkOutput("rst_ptr",    16'(ptr_cur1), 16'd522);
      checkOutput("rst_pstuff", 16'(pstuff1),  16'h0);
      checkOutput("rst_ackrej", 16'({req_ack1, req_rej1}), 16'h0);
      rst_n = 1'b1;
      tick();

      $display("[TB] normal frame at ptr 522");
      frameStart1();
      readFrame1();
      for (int i = 0; i < 9; i++) begin
         checkOutput($sformatf("norm_byte%0d", i), 16'(b1[i]), 16'(expn[i]));
         checkOutput($sformatf("norm_h3d%0d", i), 16'(h3q[i]), 16'h0);
      end
      checkOutput("norm_valid", 16'(v1[0]), 16'h1);

      $display("[TB] positive justification");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
      frameStart1();
      checkOutput("inc_ack",    16'(req_ack1), 16'h1);
      checkOutput("inc_pstuff", 16'(pstuff1),  16'h1);
      readFrame1();
      checkOutput("inc_h1", 16'(b1[0]), 16'h68);
      checkOutput("inc_h2", 16'(b1[3]), 16'hA0);
      checkOutput("inc_ptr_hold", 16'(ptr_cur1), 16'd522);
      checkOutput("inc_ack_pulse", 16'(req_ack1), 16'h0);

      $display("[TB] dec too soon after inc");
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
      frameStart1();
      checkOutput("dec_soon_rej", 16'(req_rej1), 16'h1);
      checkOutput("inc_ptr_next", 16'(ptr_cur1), 16'd523);
      checkOutput("inc_pstuff_off", 16'(pstuff1), 16'h0);
      readFrame1();
      checkOutput("p523_h1", 16'(b1[0]), 16'h6A);
      checkOutput("p523_h2", 16'(b1[3]), 16'h0B);

      frameStart1();
      frameStart1();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
      frameStart1();
      checkOutput("dec_k4_ack", 16'(req_ack1), 16'h1);
      readFrame1();
      checkOutput("dec_h1", 16'(b1[0]), 16'h6B);
      checkOutput("dec_h2", 16'(b1[3]), 16'h5E);
      checkOutput("dec_h3d_0", 16'(h3q[0]), 16'h0);
      checkOutput("dec_h3d_5", 16'(h3q[5]), 16'h0);
      checkOutput("dec_h3d_6", 16'(h3q[6]), 16'h1);
      checkOutput("dec_h3d_7", 16'(h3q[7]), 16'h1);
      checkOutput("dec_h3d_8", 16'(h3q[8]), 16'h1);
      frameStart1();
      checkOutput("dec_ptr_next", 16'(ptr_cur1), 16'd522);

      $display("[TB] invalid requests");
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 10'd0);
      frameStart1();
      checkOutput("incdec_rej", 16'({req_ack1, req_rej1}), 16'b01);
      checkOutput("incdec_pstuff", 16'(pstuff1), 16'h0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'd800);
      frameStart1();
      checkOutput("ld800_rej", 16'({req_ack1, req_rej1}), 16'b01);
      checkOutput("ld800_ptr", 16'(ptr_cur1), 16'd522);

      $display("[TB] NDF load to 782, then inc wraps");
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 10'd782);
      frameStart1();
      checkOutput("ld782_ack", 16'(req_ack1), 16'h1);
      checkOutput("ld782_ptr", 16'(ptr_cur1), 16'd782);
      readFrame1();
      checkOutput("ndf_h1", 16'(b1[0]), 16'h9B);
      checkOutput("ndf_h2", 16'(b1[3]), 16'h0E);
      frameStart1();
      frameStart1();
      frameStart1();
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
      frameStart1();
      checkOutput("inc782_ack", 16'(req_ack1), 16'h1);
      frameStart1();
      checkOutput("inc_wrap_ptr", 16'(ptr_cur1), 16'd0);
      readFrame1();
      checkOutput("p0_h1", 16'(b1[0]), 16'h68);
      checkOutput("p0_h2", 16'(b1[3]), 16'h00);

      $display("[TB] dec at ptr 0 wraps");
      frameStart1();
      frameStart1();
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 10'd0);
      frameStart1();
      checkOutput("dec0_ack", 16'(req_ack1), 16'h1);
      readFrame1();
      checkOutput("dec0_h1", 16'(b1[0]), 16'h69);
      checkOutput("dec0_h2", 16'(b1[3]), 16'h55);
      checkOutput("dec0_h3d", 16'({h3q[6], h3q[7], h3q[8]}), 16'b111);
      frameStart1();
      checkOutput("dec_wrap_ptr", 16'(ptr_cur1), 16'd782);

`ifdef AU_PTRGEN_AIS_EN
      $display("[TB] AIS");
      ais1 = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 10'd0);
      frameStart1();
      checkOutput("ais_rej", 16'({req_ack1, req_rej1}), 16'b01);
      readFrame1();
      checkOutput("ais_h1", 16'(b1[0]), 16'hFF);
      checkOutput("ais_y",  16'(b1[1]), 16'h9B);
      checkOutput("ais_h2", 16'(b1[3]), 16'hFF);
      checkOutput("ais_h3", 16'(b1[6]), 16'hFF);
      ais1 = 1'b0;
      tick();
      frameStart1();
      readFrame1();
      checkOutput("ais_rel_h1", 16'(b1[0]), 16'h9B);
      checkOutput("ais_rel_h2", 16'(b1[3]), 16'h0E);
      checkOutput("ais_rel_ptr", 16'(ptr_cur1), 16'd782);
`endif

      $display("[TB] NCH=4 NDF on channel 2");
      ptr_new4 = 40'd100 << 20;
      ld_req4  = 4'b0100;
      tick();
      ld_req4  = 4'b0000;
      txsof4   = 1'b1;
      tick();
      txsof4   = 1'b0;
      checkOutput("n4_ack", 16'(req_ack4), 16'h4);
      checkOutput("n4_rej", 16'(req_rej4), 16'h0);
      checkOutput("n4_ptr2", 16'(ptr_cur4[29:20]), 16'd100);
      checkOutput("n4_ptr0", 16'(ptr_cur4[9:0]), 16'd522);
      readFrame4();
      checkOutput("n4_p0",  16'(b4[0]),  16'h6A);
      checkOutput("n4_p1",  16'(b4[1]),  16'h6A);
      checkOutput("n4_p2",  16'(b4[2]),  16'h98);
      checkOutput("n4_p3",  16'(b4[3]),  16'h6A);
      checkOutput("n4_p4",  16'(b4[4]),  16'h9B);
      checkOutput("n4_p13", 16'(b4[13]), 16'h0A);
      checkOutput("n4_p14", 16'(b4[14]), 16'h64);
      checkOutput("n4_p15", 16'(b4[15]), 16'h0A);
      checkOutput("n4_p16", 16'(b4[16]), 16'hFF);
      checkOutput("n4_p35", 16'(b4[35]), 16'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
